// File: rtl/mips_pkg.sv
// Shared definitions for the single-issue MIPS core front end.
package mips_pkg;

  // Main-decoder opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // Fetch FSM states; encoding 2'd3 is unused and falls back to S_FETCH
  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_VALID = 2'd1,
    S_ERR   = 2'd2
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Opcode field of an instruction word
  function automatic logic [5:0] opcode(input logic [31:0] word);
    return word[31:26];
  endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Next-PC selection: jump > branch > sequential, all 32-bit wrap-around.
module next_pc_calc
  import mips_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] instr,
  input  logic [31:0] branch_imm,
  input  logic        take_branch,
  input  logic        take_jump,
  output logic [31:0] pcplus4,
  output logic [31:0] next_pc
);

  // Only the low 30 immediate bits survive the word shift; opcode bits are not part of any target
  logic unused_bits;
  assign unused_bits = ^{branch_imm[31:30], instr[31:26]};

  // Target selection with jump taking priority over branch
  always_comb begin
    pcplus4 = pc + 32'd4;
    next_pc = pcplus4;
    if (take_jump) begin
      next_pc = {pcplus4[31:28], instr[25:0], 2'b00};
    end else if (take_branch) begin
      next_pc = pcplus4 + {branch_imm[29:0], 2'b00};
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, imem handshake, instruction register,
// imem watchdog and consumed-instruction counter.
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] instr,
  output logic [5:0]  op,
  output logic [31:0] pc_out,
  output logic [31:0] pcplus4,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        take_branch,
  input  logic [31:0] branch_imm,
  input  logic        take_jump,
  output logic        fetch_err,
  output logic [31:0] fetch_count
);

  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

  fetch_state_t state, state_next;
  logic [31:0]  pc;
  logic [31:0]  ir;
  logic [7:0]   wd_cnt;
  logic [31:0]  next_pc;
  logic         fetch_done;
  logic         wd_expire;
  logic         consume;

  next_pc_calc u_next_pc (
    .pc          (pc),
    .instr       (ir),
    .branch_imm  (branch_imm),
    .take_branch (take_branch),
    .take_jump   (take_jump),
    .pcplus4     (pcplus4),
    .next_pc     (next_pc)
  );

  assign imem_addr   = pc;
  assign pc_out      = pc;
  assign instr       = ir;
  assign op          = opcode(ir);

  // Next-state decode and handshake outputs
  always_comb begin
    state_next  = state;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    fetch_done  = 1'b0;
    wd_expire   = 1'b0;
    consume     = 1'b0;
    case (state)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          fetch_done = 1'b1;
          state_next = S_VALID;
        end else if (wd_cnt == WD_LAST) begin
          wd_expire  = 1'b1;
          state_next = S_ERR;
        end
      end
      S_VALID: begin
        instr_valid = 1'b1;
        if (instr_ready) begin
          consume    = 1'b1;
          state_next = S_FETCH;
        end
      end
      S_ERR: state_next = S_ERR;
      default: state_next = S_FETCH;
    endcase
  end

  // State, PC, IR, watchdog and counter registers; reset overrides every event
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_FETCH;
      pc          <= RESET_PC;
      ir          <= '0;
      wd_cnt      <= '0;
      fetch_err   <= 1'b0;
      fetch_count <= '0;
    end else begin
      state <= state_next;
      if (fetch_done) begin
        ir     <= imem_rdata;
        wd_cnt <= '0;
      end else if (wd_expire) begin
        fetch_err <= 1'b1;
      end else if (state == S_FETCH) begin
        wd_cnt <= wd_cnt + 8'd1;
      end
      if (consume) begin
        pc          <= next_pc;
        fetch_count <= fetch_count + 32'd1;
      end
    end
  end

endmodule
